mem_stall_tracker: RTL and testbench

- Tracks outstanding memory requests per hardware thread.
- Decides when every thread in the active thread group is blocked on memory, and then issues a one-cycle mem_stall pulse with a tid_stalled index.
- Sits directly upstream of the thread-group switcher and drives its mem_stall/tid_stalled inputs. It consumes that switcher's tgrp output as feedback.
- Also gates issue of new memory requests per thread.

---
 rtl/mem_stall_tracker_if.sv | 34 +++
 rtl/mem_stall_tracker.sv | 143 ++++++++++++++
 tb/tb_mem_stall_tracker.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stall_tracker_if.sv
// Handshake/status bundle between the memory-stall tracker and its neighbours.
interface mem_stall_tracker_if #(
  parameter int unsigned NUM_THREADS       = 4,
  parameter int unsigned NUM_THREAD_GROUPS = 2
);
  localparam int unsigned TID_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
  localparam int unsigned GRP_W = (NUM_THREAD_GROUPS > 1) ? $clog2(NUM_THREAD_GROUPS) : 1;

  logic [GRP_W-1:0]       tgrp;
  logic                   req_valid;
  logic [TID_W-1:0]       req_tid;
  logic                   req_is_load;
  logic                   req_ready;
  logic                   resp_valid;
  logic [TID_W-1:0]       resp_tid;
  logic                   resp_is_load;
  logic [NUM_THREADS-1:0] thread_blocked;
  logic                   mem_stall;
  logic [TID_W-1:0]       tid_stalled;
  logic                   all_blocked;
  logic                   err;

  // Request/response source and group switcher side.
  modport master (
    output tgrp, req_valid, req_tid, req_is_load, resp_valid, resp_tid, resp_is_load,
    input  req_ready, thread_blocked, mem_stall, tid_stalled, all_blocked, err
  );

  // Tracker side.
  modport slave (
    input  tgrp, req_valid, req_tid, req_is_load, resp_valid, resp_tid, resp_is_load,
    output req_ready, thread_blocked, mem_stall, tid_stalled, all_blocked, err
  );
endinterface

// File: rtl/mem_stall_tracker.sv
// Per-thread outstanding memory request tracking; pulses mem_stall when the
// active thread group is fully blocked on memory and another group can run.
module mem_stall_tracker #(
  parameter int unsigned NUM_THREADS       = 4,
  parameter int unsigned NUM_THREAD_GROUPS = 2,
  parameter int unsigned MAX_OUTSTANDING   = 2
) (
  input logic          clk,
  input logic          rst,
  mem_stall_tracker_if.slave bus
);
  localparam int unsigned TPG   = NUM_THREADS / NUM_THREAD_GROUPS;
  localparam int unsigned TID_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
  localparam int unsigned GRP_W = (NUM_THREAD_GROUPS > 1) ? $clog2(NUM_THREAD_GROUPS) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {RUN, STALL, SETTLE, ALLBLK} state_e;

  logic [CNT_W-1:0]       cnt_q [NUM_THREADS];
  logic [CNT_W-1:0]       cnt_d [NUM_THREADS];
  logic [NUM_THREADS-1:0] pend_ld_q, pend_ld_d;
  logic [NUM_THREADS-1:0] blk_q, blk_d;
  logic [NUM_THREADS-1:0] acc, rsp, in_grp;
  logic                   err_q, err_d;
  state_e                 state_q, state_d;
  logic                   mem_stall_q, mem_stall_d;
  logic [TID_W-1:0]       tid_stalled_q, tid_stalled_d;
  logic                   all_blocked_q, all_blocked_d;
  logic                   req_ready_c;
  logic                   grp_blk, any_free, unblk_in;
  logic [TID_W-1:0]       grp_base;

  assign req_ready_c        = (cnt_q[bus.req_tid] < CNT_MAX);
  assign bus.req_ready      = req_ready_c;
  assign bus.thread_blocked = blk_q;
  assign bus.mem_stall      = mem_stall_q;
  assign bus.tid_stalled    = tid_stalled_q;
  assign bus.all_blocked    = all_blocked_q;
  assign bus.err            = err_q;

  // Decode which thread accepts a request / receives a response, and group membership.
  always_comb begin
    acc    = '0;
    rsp    = '0;
    in_grp = '0;
    for (int unsigned t = 0; t < NUM_THREADS; t++) begin
      acc[t]    = bus.req_valid & req_ready_c & (bus.req_tid == TID_W'(t));
      rsp[t]    = bus.resp_valid & (bus.resp_tid == TID_W'(t));
      in_grp[t] = (GRP_W'(t / TPG) == bus.tgrp);
    end
  end

  // Next per-thread counters, pending-load flags, blocked flags and sticky error.
  always_comb begin
    err_d = err_q;
    for (int unsigned t = 0; t < NUM_THREADS; t++) begin
      cnt_d[t]     = cnt_q[t];
      pend_ld_d[t] = pend_ld_q[t];
      if (rsp[t] && (cnt_q[t] == '0)) begin
        // Spurious response: nothing to retire, only a same-cycle request counts.
        err_d    = 1'b1;
        cnt_d[t] = acc[t] ? CNT_W'(1) : '0;
      end else if (acc[t] && !rsp[t]) begin
        cnt_d[t] = cnt_q[t] + CNT_W'(1);
      end else if (rsp[t] && !acc[t]) begin
        cnt_d[t] = cnt_q[t] - CNT_W'(1);
      end
      if (acc[t] && bus.req_is_load) begin
        pend_ld_d[t] = 1'b1;
      end else if (rsp[t] && (bus.resp_is_load || (cnt_q[t] == '0))) begin
        pend_ld_d[t] = 1'b0;
      end
      blk_d[t] = pend_ld_d[t] | (cnt_d[t] == CNT_MAX);
    end
  end

  // Group predicates from the registered blocked flags.
  always_comb begin
    grp_blk  = &(blk_q | ~in_grp);
    any_free = |(~blk_q & ~in_grp);
    unblk_in = |(~blk_q & in_grp);
    grp_base = TID_W'(32'(bus.tgrp) * TPG);
  end

  // Stall FSM next-state and registered-output values.
  always_comb begin
    state_d       = state_q;
    mem_stall_d   = 1'b0;
    tid_stalled_d = tid_stalled_q;
    case (state_q)
      RUN: begin
        if (grp_blk && any_free) begin
          state_d       = STALL;
          mem_stall_d   = 1'b1;
          tid_stalled_d = grp_base;
        end else if (grp_blk) begin
          state_d = ALLBLK;
        end
      end
      STALL:  state_d = SETTLE;
      SETTLE: state_d = RUN;
      ALLBLK: begin
        if (unblk_in) begin
          state_d = RUN;
        end else if (any_free) begin
          state_d       = STALL;
          mem_stall_d   = 1'b1;
          tid_stalled_d = grp_base;
        end
      end
      default: state_d = RUN;
    endcase
    all_blocked_d = (state_d == ALLBLK);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned t = 0; t < NUM_THREADS; t++) begin
        cnt_q[t] <= '0;
      end
      pend_ld_q     <= '0;
      blk_q         <= '0;
      err_q         <= 1'b0;
      state_q       <= RUN;
      mem_stall_q   <= 1'b0;
      tid_stalled_q <= '0;
      all_blocked_q <= 1'b0;
    end else begin
      for (int unsigned t = 0; t < NUM_THREADS; t++) begin
        cnt_q[t] <= cnt_d[t];
      end
      pend_ld_q     <= pend_ld_d;
      blk_q         <= blk_d;
      err_q         <= err_d;
      state_q       <= state_d;
      mem_stall_q   <= mem_stall_d;
      tid_stalled_q <= tid_stalled_d;
      all_blocked_q <= all_blocked_d;
    end
  end
endmodule

// File: tb/tb_mem_stall_tracker.sv
// Self-checking bench for mem_stall_tracker: directed scenarios plus a
// scoreboard of expected mem_stall pulses (tid_stalled values).
module tb_mem_stall_tracker;
  localparam int unsigned NT = 4;
  localparam int unsigned NG = 2;
  localparam int unsigned MO = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_stall_tracker_if #(.NUM_THREADS(NT), .NUM_THREAD_GROUPS(NG)) bus ();

  mem_stall_tracker #(
    .NUM_THREADS(NT), .NUM_THREAD_GROUPS(NG), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int          checks   = 0;
  int          failures = 0;
  int unsigned exp_q[$];
  logic        prev_stall = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse monitor: every mem_stall must match a queued expectation.
  always @(negedge clk) begin
    if (bus.mem_stall === 1'b1) begin
      check_eq("stall_back_to_back", 32'(prev_stall), 32'd0);
      if (exp_q.size() == 0) check_eq("mem_stall_unexpected", 32'(bus.mem_stall), 32'd0);
      else                   check_eq("tid_stalled", 32'(bus.tid_stalled), exp_q.pop_front());
    end
    prev_stall = bus.mem_stall;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req_valid    = 1'b0;
    bus.req_is_load  = 1'b0;
    bus.resp_valid   = 1'b0;
    bus.resp_is_load = 1'b0;
  endtask

  task automatic req(input logic [1:0] tid, input logic ld);
    bus.req_valid   = 1'b1;
    bus.req_tid     = tid;
    bus.req_is_load = ld;
  endtask

  task automatic resp(input logic [1:0] tid, input logic ld);
    bus.resp_valid   = 1'b1;
    bus.resp_tid     = tid;
    bus.resp_is_load = ld;
  endtask

  task automatic probe_ready(input logic [1:0] tid, input logic exp, input string tag);
    bus.req_tid = tid;
    #1;
    check_eq(tag, 32'(bus.req_ready), 32'(exp));
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic load_all_grp0_last();
    req(2'd2, 1'b1); tick();
    req(2'd3, 1'b1); tick();
    req(2'd0, 1'b1); tick();
    req(2'd1, 1'b1); tick();
    idle();
  endtask

  initial begin
    bus.tgrp     = '0;
    bus.req_tid  = '0;
    bus.resp_tid = '0;
    idle();
    rst = 1'b1;
    tick();
    tick();
    // Reset state
    check_eq("rst_blocked",     32'(bus.thread_blocked), 32'h0);
    check_eq("rst_mem_stall",   32'(bus.mem_stall),      32'h0);
    check_eq("rst_tid_stalled", 32'(bus.tid_stalled),    32'h0);
    check_eq("rst_all_blocked", 32'(bus.all_blocked),    32'h0);
    check_eq("rst_err",         32'(bus.err),            32'h0);
    rst = 1'b0;

    // 1: loads on tid0, tid1 block group 0 -> pulse, settle, re-evaluate, pulse again
    req(2'd0, 1'b1); tick(); idle();
    check_eq("t1_blk_tid0", 32'(bus.thread_blocked), 32'h1);
    req(2'd1, 1'b1);
    exp_q.push_back(0);
    exp_q.push_back(0);
    tick(); idle();
    check_eq("t1_blk_0011", 32'(bus.thread_blocked), 32'h3);
    check_eq("t1_stall_lo0", 32'(bus.mem_stall), 32'h0);
    tick();
    check_eq("t1_stall_hi", 32'(bus.mem_stall), 32'h1);
    tick();
    check_eq("t1_settle_lo", 32'(bus.mem_stall), 32'h0);
    tick();
    check_eq("t1_run_lo", 32'(bus.mem_stall), 32'h0);
    tick();
    check_eq("t1_stall_again", 32'(bus.mem_stall), 32'h1);
    check_eq("t1_tid_hold", 32'(bus.tid_stalled), 32'h0);
    resp(2'd0, 1'b1); tick(); idle();
    check_eq("t1_blk_after_r0", 32'(bus.thread_blocked), 32'h2);
    resp(2'd1, 1'b1); tick(); idle();
    check_eq("t1_blk_clear", 32'(bus.thread_blocked), 32'h0);
    tick(); tick(); tick();

    // 2: two stores saturate tid2; third is refused; responses drain it
    do_reset();
    req(2'd2, 1'b0); #1;
    check_eq("t2_ready_cnt0", 32'(bus.req_ready), 32'h1);
    tick();
    req(2'd2, 1'b0); #1;
    check_eq("t2_ready_cnt1", 32'(bus.req_ready), 32'h1);
    tick(); idle();
    check_eq("t2_blk_full", 32'(bus.thread_blocked), 32'h4);
    probe_ready(2'd2, 1'b0, "t2_ready_full");
    req(2'd2, 1'b0); tick(); idle();
    check_eq("t2_blk_still", 32'(bus.thread_blocked), 32'h4);
    resp(2'd2, 1'b0); tick(); idle();
    check_eq("t2_blk_unblk", 32'(bus.thread_blocked), 32'h0);
    probe_ready(2'd2, 1'b1, "t2_ready_cnt1b");
    resp(2'd2, 1'b0); tick(); idle();
    check_eq("t2_err_none", 32'(bus.err), 32'h0);
    resp(2'd2, 1'b0); tick(); idle();
    check_eq("t2_err_drained", 32'(bus.err), 32'h1);

    // 3: same-tid request and response leave cnt[3] at 1
    do_reset();
    req(2'd3, 1'b0); tick();
    req(2'd3, 1'b0); resp(2'd3, 1'b0); #1;
    check_eq("t3_ready_same", 32'(bus.req_ready), 32'h1);
    tick(); idle();
    check_eq("t3_blk", 32'(bus.thread_blocked), 32'h0);
    check_eq("t3_err", 32'(bus.err), 32'h0);
    probe_ready(2'd3, 1'b1, "t3_ready_after");
    req(2'd3, 1'b0); tick(); idle();
    check_eq("t3_blk_full", 32'(bus.thread_blocked), 32'h8);

    // 4b: all blocked, then an in-group thread unblocks -> back to RUN without a pulse
    do_reset();
    load_all_grp0_last();
    check_eq("t4b_blk_all", 32'(bus.thread_blocked), 32'hF);
    tick();
    check_eq("t4b_allblk", 32'(bus.all_blocked), 32'h1);
    resp(2'd0, 1'b1); tick(); idle();
    tick();
    check_eq("t4b_allblk_clr", 32'(bus.all_blocked), 32'h0);
    tick(); tick(); tick();

    // 4: all blocked, out-of-group unblock -> STALL; 6: reset during STALL
    do_reset();
    load_all_grp0_last();
    check_eq("t4_blk_all", 32'(bus.thread_blocked), 32'hF);
    check_eq("t4_stall_lo", 32'(bus.mem_stall), 32'h0);
    tick();
    check_eq("t4_allblk", 32'(bus.all_blocked), 32'h1);
    resp(2'd2, 1'b1);
    exp_q.push_back(0);
    tick(); idle();
    check_eq("t4_blk_b", 32'(bus.thread_blocked), 32'hB);
    check_eq("t4_allblk_hold", 32'(bus.all_blocked), 32'h1);
    tick();
    check_eq("t4_stall_hi", 32'(bus.mem_stall), 32'h1);
    check_eq("t4_allblk_lo", 32'(bus.all_blocked), 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("t6_stall_lo", 32'(bus.mem_stall), 32'h0);
    check_eq("t6_blk_clr", 32'(bus.thread_blocked), 32'h0);
    check_eq("t6_allblk", 32'(bus.all_blocked), 32'h0);
    for (int t = 0; t < 4; t++) probe_ready(2'(t), 1'b1, "t6_ready_cnt0");
    req(2'd0, 1'b0); tick();
    req(2'd0, 1'b0); tick(); idle();
    check_eq("t6_cnt_from0", 32'(bus.thread_blocked), 32'h1);
    tick(); tick(); tick();

    // 5: response with cnt==0 sets sticky err, cnt stays 0
    do_reset();
    resp(2'd1, 1'b1); tick(); idle();
    check_eq("t5_err_set", 32'(bus.err), 32'h1);
    tick(); tick();
    check_eq("t5_err_sticky", 32'(bus.err), 32'h1);
    probe_ready(2'd1, 1'b1, "t5_ready_cnt0");
    req(2'd1, 1'b0); tick(); idle();
    check_eq("t5_blk_cnt1", 32'(bus.thread_blocked), 32'h0);
    req(2'd1, 1'b0); tick(); idle();
    check_eq("t5_blk_cnt2", 32'(bus.thread_blocked), 32'h2);
    do_reset();
    check_eq("t5_err_rst", 32'(bus.err), 32'h0);

    tick(); tick();
    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
